// File: rtl/fa_bist_checker.sv
// fa_bist_checker: on-chip BIST for a single full adder.
// Sweeps all eight {Cin,B,A} vectors into the adder under test, samples
// Sum/Carry after a programmable settle window and compares them against
// A+B+Cin. Reports pass/fail, a saturating error count and the first failing
// vector.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             1-cycle request, accepted only when idle or done
//   A, B, Cin         registered operands driven into the adder
//   Sum, Carry        adder outputs, sampled only in the check cycle
//   busy              high while a sweep is in progress
//   done              high once the sweep finished, held until next start
//   pass              valid with done; 1 iff no vector mismatched
//   err_cnt           number of mismatching vectors, saturating
//   first_fail        {Cin,B,A} of the first mismatch, 0 if none
module fa_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             Cin,
  input  logic             Sum,
  input  logic             Carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_fail
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_q, seen_d;
  logic               a_d, b_d, cin_d;
  logic               busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_d;
  logic [2:0]         ff_d;
  logic [1:0]         exp_c;

  // Reference response for the vector currently driven: {carry, sum}
  assign exp_c = {(Cin & B) | (Cin & A) | (A & B), A ^ B ^ Cin};

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      A          <= 1'b0;
      B          <= 1'b0;
      Cin        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      A          <= a_d;
      B          <= b_d;
      Cin        <= cin_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_cnt    <= err_d;
      first_fail <= ff_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    a_d     = A;
    b_d     = B;
    cin_d   = Cin;
    pass_d  = pass;
    err_d   = err_cnt;
    ff_d    = first_fail;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          idx_d   = 3'd0;
          err_d   = '0;
          ff_d    = 3'd0;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_APPLY: begin
        {cin_d, b_d, a_d} = idx_q;
        cnt_d             = CNT_W'(SETTLE_CYCLES);
        state_d           = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if ({Carry, Sum} != exp_c) begin
          if (err_cnt != ERR_MAX) err_d = err_cnt + ERR_W'(1);
          // Flag rather than err_cnt==0 so vector 0 failing is still latched once
          if (!seen_q) begin
            seen_d = 1'b1;
            ff_d   = idx_q;
          end
        end
        if (idx_q == 3'd7) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_APPLY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags registered from the upcoming state so they track it exactly
    busy_d = (state_d == ST_APPLY) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Testbench for fa_bist_checker: three checker instances (settle 1 / err width 4,
// settle 1 / err width 2, settle 2 / err width 4) each drive their own full-adder
// model with injectable per-vector faults and an optional 2-clock output delay.
// Expected results come from a per-sweep behavioural model.
module tb_fa_bist_checker;

  localparam int FA_DELAY = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] a, b, cin, sum, carry, busy, done, pass;
  logic [2:0] ff [3];
  logic [3:0] err0, err2;
  logic [1:0] err1;
  logic [3:0] err_v [3];

  logic [7:0] sum_flip;   // per-vector fault: invert Sum
  logic [7:0] car_flip;   // per-vector fault: invert Carry
  logic       dly;        // route adder outputs through a 2-clock delay
  logic [2:0] prev_v [3]; // vector held on the operands before a sweep starts

  int n_checks;
  int n_errors;

  fa_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .A(a[0]), .B(b[0]), .Cin(cin[0]),
    .Sum(sum[0]), .Carry(carry[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_cnt(err0), .first_fail(ff[0]));

  fa_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .A(a[1]), .B(b[1]), .Cin(cin[1]),
    .Sum(sum[1]), .Carry(carry[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_cnt(err1), .first_fail(ff[1]));

  fa_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start), .A(a[2]), .B(b[2]), .Cin(cin[2]),
    .Sum(sum[2]), .Carry(carry[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_cnt(err2), .first_fail(ff[2]));

  assign err_v[0] = err0;
  assign err_v[1] = {2'b00, err1};
  assign err_v[2] = err2;

  // Full-adder models with fault injection and optional output delay
  for (genvar g = 0; g < 3; g++) begin : g_fa
    logic [2:0] v;
    logic [1:0] fa_c, d1, d2, o;
    assign v    = {cin[g], b[g], a[g]};
    assign fa_c = ({1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]}) ^ {car_flip[v], sum_flip[v]};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d1 <= 2'b00;
        d2 <= 2'b00;
      end else begin
        d1 <= fa_c;
        d2 <= d1;
      end
    end
    assign o        = dly ? d2 : fa_c;
    assign sum[g]   = o[0];
    assign carry[g] = o[1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input int g);
    return (g == 2) ? 2 : 1;
  endfunction

  function automatic int errw_of(input int g);
    return (g == 1) ? 2 : 4;
  endfunction

  function automatic int ones(input int x);
    return (x & 1) + ((x >> 1) & 1) + ((x >> 2) & 1);
  endfunction

  // Expected outcome of one complete sweep: a delayed adder whose latency
  // exceeds the settle window answers with the previous vector's result.
  function automatic void ref_sweep(input int g, input logic [2:0] prev,
                                    output logic exp_pass, output logic [3:0] exp_err,
                                    output logic [2:0] exp_ff);
    int errs, v, obs, sat;
    bit found;
    errs   = 0;
    found  = 0;
    exp_ff = 3'd0;
    for (int idx = 0; idx < 8; idx++) begin
      if (dly && settle_of(g) < FA_DELAY) v = (idx == 0) ? int'(prev) : idx - 1;
      else v = idx;
      obs = ones(v) ^ (int'(car_flip[v]) * 2 + int'(sum_flip[v]));
      if (obs != ones(idx)) begin
        errs++;
        if (!found) begin
          found  = 1;
          exp_ff = 3'(idx);
        end
      end
    end
    sat      = (1 << errw_of(g)) - 1;
    exp_err  = 4'((errs > sat) ? sat : errs);
    exp_pass = (errs == 0);
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < 3; g++)
      check_eq($sformatf("%s%0d", tag, g),
               32'({a[g], b[g], cin[g], busy[g], done[g], pass[g], err_v[g], ff[g]}), 32'd0);
  endtask

  // One sweep: mid_n>0 pulses start at edge mid_n (while busy), rst_at>0 resets
  // asynchronously just after edge rst_at and abandons the sweep.
  task automatic run_sweep(input int mid_n, input int rst_at);
    logic       ep [3];
    logic [3:0] ee [3];
    logic [2:0] ef [3];
    for (int g = 0; g < 3; g++) ref_sweep(g, prev_v[g], ep[g], ee[g], ef[g]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("accept_busy", 32'(busy[0]), 32'd1);
    check_eq("accept_done", 32'(done[0]), 32'd0);
    check_eq("accept_err", 32'(err_v[0]), 32'd0);
    check_eq("accept_pass", 32'(pass[0]), 32'd0);
    for (int n = 1; n <= 34; n++) begin
      start = (n == mid_n);
      @(negedge clk);
      if (n % 3 == 2 && n < 24)
        check_eq($sformatf("vec@%0d", n), 32'({cin[0], b[0], a[0]}), 32'(n / 3));
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) prev_v[g] = 3'd0;
        repeat (2) @(negedge clk);
        check_eq("idle_after_rst", 32'({busy, done}), 32'd0);
        return;
      end
      if (n == 23) check_eq("done_early_s1", 32'({done[1], done[0]}), 32'd0);
      if (n == 24) check_eq("done_s1", 32'({busy[0], done[1], done[0]}), 32'b011);
      if (n == 31) check_eq("done_early_s2", 32'(done[2]), 32'd0);
      if (n == 32) check_eq("done_s2", 32'({busy[2], done[2]}), 32'b01);
    end
    start = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check_eq($sformatf("done%0d", g), 32'(done[g]), 32'd1);
      check_eq($sformatf("pass%0d", g), 32'(pass[g]), 32'(ep[g]));
      check_eq($sformatf("err%0d", g), 32'(err_v[g]), 32'(ee[g]));
      check_eq($sformatf("first_fail%0d", g), 32'(ff[g]), 32'(ef[g]));
      prev_v[g] = 3'd7;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    sum_flip = 8'h00;
    car_flip = 8'h00;
    dly      = 1'b0;
    for (int g = 0; g < 3; g++) prev_v[g] = 3'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Golden adder
    run_sweep(0, 0);
    // Sum stuck at 0, plus a start pulse while busy
    sum_flip = 8'h96;
    run_sweep(7, 0);
    // Carry inverted on every vector: saturates the 2-bit counter
    sum_flip = 8'h00;
    car_flip = 8'hFF;
    run_sweep(0, 0);
    // Reset during vector 4, then a clean sweep
    run_sweep(0, 13);
    car_flip = 8'h00;
    run_sweep(0, 0);
    // Adder with 2-clock output latency
    dly = 1'b1;
    run_sweep(0, 0);
    dly = 1'b0;

    // Randomized faults, delay, stray starts and resets
    for (int it = 0; it < 14; it++) begin
      sum_flip = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      car_flip = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      dly      = 1'($urandom_range(0, 1));
      run_sweep(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 22)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
